mips_mem_arbiter: RTL and testbench
===================================

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10: word-address width of the shared memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, legal 1..15: consecutive denied fetch cycles before a forced fetch grant.
REQ-003 SHALL have port clk1, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch request.
REQ-006 SHALL have port if_addr, input, AW: fetch word address.
REQ-007 SHALL have port if_gnt, output, 1: fetch accepted this cycle.
REQ-008 SHALL have port if_rvalid, output, 1: fetch data valid.
REQ-009 SHALL have port if_rdata, output, 32: fetch data.
REQ-010 SHALL have port d_req, input, 1: data-port request.
REQ-011 SHALL have port d_we, input, 1: data write (1) or read (0).
REQ-012 SHALL have port d_addr, input, AW: data word address.
REQ-013 SHALL have port d_wdata, input, 32: store data.
REQ-014 SHALL have port d_gnt, output, 1: data access accepted this cycle.
REQ-015 SHALL have port d_rvalid, output, 1: load data valid.
REQ-016 SHALL have port d_rdata, output, 32: load data.
REQ-017 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, 32), mem_rdata (input, 32): single-port synchronous memory, read data one cycle after mem_en.

Function
REQ-018 SHALL grant at most one requester per cycle; if_gnt and d_gnt are combinational from requests and registered state, never both high.
REQ-019 SHALL, by default, give d_req priority over if_req (loads/stores drain the MEM stage before fetch).
REQ-020 SHALL drive mem_en=1 exactly when either grant is high, with mem_addr/mem_we/mem_wdata taken from the granted port; mem_we=0 for fetch grants.
REQ-021 SHALL hold mem_en=0, mem_we=0 and mem_addr/mem_wdata at 0 when neither grant is high.
REQ-022 SHALL assert if_rvalid (resp. d_rvalid) for exactly one cycle, one cycle after a fetch grant (resp. data read grant), with if_rdata/d_rdata = mem_rdata in that cycle.
REQ-023 SHALL NOT assert d_rvalid for granted writes.
REQ-024 SHALL require a requester to hold req, address, d_we and d_wdata stable until its grant; a request dropped before grant is discarded with no memory access.
REQ-025 SHALL sustain one access per cycle back-to-back; a new grant in the cycle an rvalid is returned is permitted.
REQ-026 SHALL present if_rdata and d_rdata as 0 when the corresponding rvalid is low.
REQ-027 SHALL keep registered response-tag state: IDLE (no read outstanding), RESP_IF, RESP_D; next state is RESP_IF on fetch grant, RESP_D on data read grant, IDLE otherwise.

Reset
REQ-028 SHALL, while rst=1, force if_rvalid=0, d_rvalid=0, response state IDLE, starvation counter 0, independent of clk1.
REQ-029 SHALL, when reset asserts with a read outstanding, drop that response with no rvalid after release.
REQ-030 SHALL suppress both grants and mem_en while rst=1.

Configuration
REQ-031 SHALL, when macro MEM_ARB_STARVE_EN is defined, include a 4-bit counter that increments each cycle if_req=1 and if_gnt=0, clears on fetch grant or if_req=0, and, when the counter equals STARVE_LIMIT, grants fetch over a pending data request for that cycle.
REQ-032 SHALL, when MEM_ARB_STARVE_EN is undefined, omit the counter and apply strict data priority.

Verification
REQ-033 SHALL cover: if_req alone, if_addr=5, mem[5]=32'h2801000a -> if_gnt same cycle, if_rvalid next cycle with if_rdata=32'h2801000a.
REQ-034 SHALL cover: if_req and d_req (read, addr 8) together -> d_gnt=1, if_gnt=0; d_rvalid next cycle; fetch granted cycle after d_req drops.
REQ-035 SHALL cover: d_req write addr 3, d_wdata=32'h0000001e, then fetch addr 3 -> no d_rvalid; if_rdata=32'h0000001e.
REQ-036 SHALL cover: with MEM_ARB_STARVE_EN, STARVE_LIMIT=4, d_req and if_req held continuously -> if_gnt on 5th cycle, then counter restarts; without macro, if_gnt never while d_req high.
REQ-037 SHALL cover: rst pulsed asynchronously the cycle after a fetch grant -> if_rvalid stays 0; after release, first request serviced normally.
REQ-038 SHALL cover: alternating fetch reads for 8 consecutive cycles -> 8 rvalid pulses, one per cycle, data in address order.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Arbitrates a MIPS fetch port and data port onto one single-port synchronous memory.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_EN.
module mips_mem_arbiter #(
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} resp_e;

  resp_e resp_q, resp_d;
  logic  force_if;

`ifdef MEM_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) starve_d = 4'd0;
    else                   starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end

  // Once fetch has waited STARVE_LIMIT cycles it wins over data for one cycle.
  assign force_if = (starve_q == STARVE_LIMIT[3:0]);
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT[3:0];
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && (!d_req || force_if)) if_gnt = 1'b1;
      else if (d_req)                     d_gnt  = 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Response tag: which port owns the read data arriving next cycle.
  always_comb begin
    resp_d = IDLE;
    if (if_gnt)              resp_d = RESP_IF;
    else if (d_gnt && !d_we) resp_d = RESP_D;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) resp_q <= IDLE;
    else     resp_q <= resp_d;
  end

  assign if_rvalid = (resp_q == RESP_IF);
  assign d_rvalid  = (resp_q == RESP_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural single-port memory.
// Starvation vectors follow MEM_ARB_STARVE_EN when it is defined for the build.
module tb_mips_mem_arbiter;
  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [31:0]   d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0]   if_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [31:0]   mem [0:(1<<AW)-1];

  int vecs = 0;
  int errs = 0;

  mips_mem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk1 = ~clk1;

  // Memory preloads to 0x10000000+addr (mem[5] holds an instruction word).
  always @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h1000_0000 + i;
      mem[5]    <= 32'h2801_000a;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic ir, input logic [AW-1:0] ia, input logic dr,
                     input logic dw, input logic [AW-1:0] da, input logic [31:0] wd);
    @(posedge clk1);
    #1;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
    @(negedge clk1);
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  logic exp_if;
  logic prev_even;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = 32'd0;

    // reset: no grants, no memory access, no responses
    drv(1'b1, 10'd5, 1'b1, 1'b0, 10'd8, 32'd0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    @(posedge clk1);
    #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;

    // lone fetch of address 5
    drv(1'b1, 10'd5, 1'b0, 1'b0, '0, 32'd0);
    chk("f5_if_gnt", if_gnt, 1);
    chk("f5_d_gnt", d_gnt, 0);
    chk("f5_mem_en", mem_en, 1);
    chk("f5_mem_we", mem_we, 0);
    chk("f5_mem_addr", mem_addr, 5);
    idle();
    chk("f5_rvalid", if_rvalid, 1);
    chk("f5_rdata", if_rdata, 32'h2801_000a);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_addr", mem_addr, 0);
    idle();
    chk("f5_rvalid_drop", if_rvalid, 0);
    chk("f5_rdata_zero", if_rdata, 0);

    // simultaneous fetch and data read: data wins, fetch follows
    drv(1'b1, 10'd6, 1'b1, 1'b0, 10'd8, 32'd0);
    chk("pri_d_gnt", d_gnt, 1);
    chk("pri_if_gnt", if_gnt, 0);
    chk("pri_mem_addr", mem_addr, 8);
    drv(1'b1, 10'd6, 1'b0, 1'b0, '0, 32'd0);
    chk("pri_if_gnt2", if_gnt, 1);
    chk("pri_d_rvalid", d_rvalid, 1);
    chk("pri_d_rdata", d_rdata, 32'h1000_0008);
    chk("pri_mem_addr2", mem_addr, 6);
    idle();
    chk("pri_if_rvalid", if_rvalid, 1);
    chk("pri_if_rdata", if_rdata, 32'h1000_0006);
    chk("pri_d_rvalid_drop", d_rvalid, 0);

    // store then fetch same word
    drv(1'b0, '0, 1'b1, 1'b1, 10'd3, 32'h0000_001e);
    chk("st_d_gnt", d_gnt, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 3);
    chk("st_mem_wdata", mem_wdata, 32'h0000_001e);
    drv(1'b1, 10'd3, 1'b0, 1'b0, '0, 32'd0);
    chk("st_no_d_rvalid", d_rvalid, 0);
    chk("st_if_gnt", if_gnt, 1);
    chk("st_fetch_wdata", mem_wdata, 0);
    idle();
    chk("st_if_rdata", if_rdata, 32'h0000_001e);
    chk("st_no_d_rvalid2", d_rvalid, 0);

    // both held continuously for 10 cycles
    for (int k = 1; k <= 10; k++) begin
      drv(1'b1, 10'd2, 1'b1, 1'b0, 10'd9, 32'd0);
`ifdef MEM_ARB_STARVE_EN
      exp_if = (k % 5 == 0);
`else
      exp_if = 1'b0;
`endif
      chk($sformatf("starve_if_gnt_%0d", k), if_gnt, exp_if);
      chk($sformatf("starve_d_gnt_%0d", k), d_gnt, !exp_if);
    end
    idle();
    idle();

    // fetch granted, then asynchronous reset mid-cycle kills the response
    drv(1'b1, 10'd5, 1'b0, 1'b0, '0, 32'd0);
    chk("ar_if_gnt", if_gnt, 1);
    @(posedge clk1);
    #1;
    if_req = 1'b1; if_addr = 10'd4;
    #1;
    rst = 1'b1;
    @(negedge clk1);
    chk("ar_if_rvalid", if_rvalid, 0);
    chk("ar_if_rdata", if_rdata, 0);
    chk("ar_if_gnt_rst", if_gnt, 0);
    chk("ar_mem_en_rst", mem_en, 0);
    @(posedge clk1);
    #1;
    rst = 1'b0; if_req = 1'b0;
    @(negedge clk1);
    chk("ar_if_rvalid_rel", if_rvalid, 0);
    drv(1'b1, 10'd7, 1'b0, 1'b0, '0, 32'd0);
    chk("ar_post_gnt", if_gnt, 1);
    idle();
    chk("ar_post_rvalid", if_rvalid, 1);
    chk("ar_post_rdata", if_rdata, 32'h1000_0007);

    // alternating fetch / data reads, addresses 10..17, back to back
    for (int i = 0; i <= 8; i++) begin
      if (i == 8)          idle();
      else if (i % 2 == 0) drv(1'b1, AW'(10 + i), 1'b0, 1'b0, '0, 32'd0);
      else                 drv(1'b0, '0, 1'b1, 1'b0, AW'(10 + i), 32'd0);
      if (i < 8)
        chk($sformatf("alt_gnt_%0d", i), {if_gnt, d_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i >= 1) begin
        prev_even = ((i - 1) % 2 == 0);
        chk($sformatf("alt_rvalid_%0d", i), {if_rvalid, d_rvalid}, prev_even ? 2'b10 : 2'b01);
        chk($sformatf("alt_rdata_%0d", i), prev_even ? if_rdata : d_rdata,
            32'h1000_0000 + 32'(10 + i - 1));
      end
    end
    idle();
    chk("alt_quiet", {if_rvalid, d_rvalid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
